// File: rtl/tt_lut_engine.sv
// tt_lut_engine: runtime-loadable N_IN-input truth-table evaluator.
//
// Purpose
//   Evaluates out_data = table[in_data] with one cycle of latency. The table is
//   double-registered: loads are assembled LSB slice first in a staging table
//   over several beats. They are copied into the active table only when the
//   load is well-formed, which means exactly BEATS beats with cfg_last on the
//   final beat. Malformed loads set the sticky err_cfg flag and leave the
//   active table untouched. The next good load clears err_cfg.
//
// Build option
//   TT_LUT_SHADOW_EN : when defined, evaluation keeps running during a load
//                      (LOAD/DRAIN/COMMIT) against the active table. When
//                      undefined, in_ready is held low outside IDLE. A result
//                      already held on the output still drains.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   cfg_valid  in   config beat offered
//   cfg_ready  out  config beat accepted when cfg_valid & cfg_ready
//   cfg_data   in   LOAD_W-bit table slice, LSB slice first
//   cfg_last   in   final beat of a table load
//   in_valid   in   input vector offered
//   in_ready   out  vector accepted when in_valid & in_ready
//   in_data    in   N_IN-bit table index (bit 0 = index LSB)
//   out_valid  out  result held
//   out_ready  in   result consumed when out_valid & out_ready
//   out_data   out  table[in_data] of the accepted vector
//   err_cfg    out  sticky malformed-load flag

module tt_lut_engine #(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned LOAD_W   = 4,
    parameter logic [63:0] RESET_TT = 64'h409B
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LOAD_W-1:0] cfg_data,
    input  logic              cfg_last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_data,
    output logic              err_cfg
);

    localparam int unsigned     TT_W      = 1 << N_IN;
    localparam int unsigned     BEATS     = TT_W / LOAD_W;
    localparam int unsigned     CNT_W     = $clog2(BEATS + 1);
    localparam logic [TT_W-1:0] RESET_VAL = RESET_TT[TT_W-1:0];
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain,
        StCommit
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TT_W-1:0]   staging_q, staging_d;
    logic [TT_W-1:0]   active_q, active_d;
    logic              err_q, err_d;
    logic              out_valid_q, out_valid_d;
    logic              out_data_q, out_data_d;

    logic cfg_fire;
    logic in_fire;
    logic eval_en;

    // ------------------------------------------------------------------
    // Config FSM: next state, staging writes, commit
    // ------------------------------------------------------------------
    assign cfg_ready = (state_q != StCommit);
    assign cfg_fire  = cfg_valid & cfg_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        staging_d = staging_q;
        active_d  = active_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (cfg_fire) begin
                    staging_d[LOAD_W-1:0] = cfg_data;
                    cnt_d                 = CNT_W'(1);
                    if (cfg_last) begin
                        if (BEATS == 1) begin
                            state_d = StCommit;
                        end else begin
                            // Load ended too early: flag it, stay ready for a new load.
                            err_d = 1'b1;
                        end
                    end else if (BEATS == 1) begin
                        // A single-beat table without cfg_last is already over-long.
                        err_d   = 1'b1;
                        state_d = StDrain;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end

            StLoad: begin
                if (cfg_fire) begin
                    // Constant-base slice writes keep the select widths exact.
                    for (int b = 1; b < int'(BEATS); b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            staging_d[b*LOAD_W +: LOAD_W] = cfg_data;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cfg_last) begin
                        if (cnt_q == LAST_IDX) begin
                            state_d = StCommit;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end else if (cnt_q == LAST_IDX) begin
                        // Table is full but the sender keeps going: swallow the rest.
                        err_d   = 1'b1;
                        state_d = StDrain;
                    end
                end
            end

            StDrain: begin
                if (cfg_fire && cfg_last) begin
                    state_d = StIdle;
                end
            end

            StCommit: begin
                active_d = staging_q;
                err_d    = 1'b0;
                cnt_d    = '0;
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Evaluation path: one-deep output register with valid/ready
    // ------------------------------------------------------------------
`ifdef TT_LUT_SHADOW_EN
    assign eval_en = 1'b1;
`else
    assign eval_en = (state_q == StIdle);
`endif

    assign in_ready = (~out_valid_q | out_ready) & eval_en;
    assign in_fire  = in_valid & in_ready;

    // A vector accepted in the COMMIT cycle reads active_q before it is overwritten.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = active_q[in_data];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            staging_q   <= '0;
            active_q    <= RESET_VAL;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            staging_q   <= staging_d;
            active_q    <= active_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err_cfg   = err_q;

endmodule

// File: tb/tb_tt_lut_engine.sv
// tb_tt_lut_engine: self-checking bench for tt_lut_engine (N_IN=4, LOAD_W=4).
//
// The reference model treats the table as a 16-bit word and a load as a list
// of beats. A load of exactly BEATS beats replaces the table with the beats
// concatenated LSB slice first and clears the error flag. Any other length
// sets the error flag and keeps the table. Evaluation results are tracked in
// a FIFO of expected outputs.

module tb_tt_lut_engine;

    localparam int unsigned N_IN   = 4;
    localparam int unsigned LOAD_W = 4;
    localparam int unsigned TT_W   = 16;
    localparam int unsigned BEATS  = 4;

`ifdef TT_LUT_SHADOW_EN
    localparam logic SHADOW = 1'b1;
`else
    localparam logic SHADOW = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [LOAD_W-1:0] cfg_data;
    logic              cfg_last;
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_data;
    logic              err_cfg;

    tt_lut_engine #(
        .N_IN     (N_IN),
        .LOAD_W   (LOAD_W),
        .RESET_TT (64'h409B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_cfg   (err_cfg)
    );

    always #5 clk = ~clk;

    int unsigned     n_vec = 0;
    int unsigned     n_err = 0;
    logic [TT_W-1:0] tt_m;
    logic            err_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [LOAD_W-1:0] d, input logic l);
        int g = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        #1;
        while (!cfg_ready && g < 8) begin
            step();
            g++;
        end
        check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    // Sends k beats taken LSB slice first from 'beats', last flag on beat k.
    task automatic do_load(input int k, input logic [31:0] beats);
        for (int j = 0; j < k; j++) begin
            send_beat(beats[j*LOAD_W +: LOAD_W], (j == k - 1));
        end
        if (k == int'(BEATS)) begin
            tt_m  = beats[TT_W-1:0];
            err_m = 1'b0;
        end else begin
            err_m = 1'b1;
        end
        step();
        step();
        check("load_err", 32'(err_cfg), 32'(err_m));
        check("load_cfg_ready", 32'(cfg_ready), 32'd1);
    endtask

    // Streams every index back-to-back and compares against the model table.
    task automatic sweep(input string tag);
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < int'(TT_W); i++) begin
            int g = 0;
            in_valid = 1'b1;
            in_data  = N_IN'(i);
            #1;
            while (!in_ready && g < 8) begin
                step();
                g++;
            end
            step();
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_data"}, 32'(out_data), 32'(tt_m[i]));
        end
        in_valid = 1'b0;
        step();
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic rand_eval(input int n);
        logic q[$];
        for (int c = 0; c < n; c++) begin
            in_valid  = logic'($urandom % 2);
            in_data   = N_IN'($urandom);
            out_ready = (($urandom % 4) != 0);
            #1;
            check("rand_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("rand_spurious", 32'd1, 32'd0);
                else               check("rand_out", 32'(out_data), 32'(q.pop_front()));
            end
            if (in_valid && in_ready) q.push_back(tt_m[in_data]);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_valid) begin
                if (q.size() == 0) check("rand_spurious", 32'd1, 32'd0);
                else               check("rand_out", 32'(out_data), 32'(q.pop_front()));
            end
            step();
        end
        check("rand_q_empty", 32'(q.size()), 32'd0);
        check("rand_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tt_m      = 16'h409B;
        err_m     = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_err", 32'(err_cfg), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0;

        // Reset table, LSB first.
        sweep("rst_tt");

        // Output backpressure holds the result and blocks new input.
        in_valid  = 1'b1;
        in_data   = 4'd7;
        out_ready = 1'b0;
        step();
        in_data = 4'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'(tt_m[7]));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_drop", 32'(out_valid), 32'd0);

        // Well-formed load F,0,F,0: in_ready gating during load, one-cycle COMMIT.
        send_beat(4'hF, 1'b0);
        check("load_in_ready", 32'(in_ready), 32'(SHADOW));
        send_beat(4'h0, 1'b0);
        send_beat(4'hF, 1'b0);
        send_beat(4'h0, 1'b1);
        check("commit_cfg_ready", 32'(cfg_ready), 32'd0);
        check("commit_in_ready", 32'(in_ready), 32'(SHADOW));
        step();
        check("post_commit_cfg_ready", 32'(cfg_ready), 32'd1);
        check("post_commit_in_ready", 32'(in_ready), 32'd1);
        check("post_commit_err", 32'(err_cfg), 32'd0);
        tt_m = 16'h0F0F;
        sweep("tt_0f0f");

        // Short load: error, table unchanged; a good load then clears the flag.
        do_load(2, 32'h0000_00A5);
        sweep("short_keep");
        do_load(4, 32'h0000_1234);
        sweep("tt_1234");

        // Long load: error raised on the 4th beat, 5th beat swallowed.
        send_beat(4'h1, 1'b0);
        send_beat(4'h2, 1'b0);
        send_beat(4'h3, 1'b0);
        send_beat(4'h4, 1'b0);
        check("long_err_4th", 32'(err_cfg), 32'd1);
        send_beat(4'h5, 1'b1);
        step();
        check("long_err_end", 32'(err_cfg), 32'd1);
        check("long_cfg_ready", 32'(cfg_ready), 32'd1);
        err_m = 1'b1;
        sweep("long_keep");

        // Reset in the middle of a load.
        do_load(4, 32'h0000_BEEF);
        sweep("tt_beef");
        in_valid  = 1'b1;
        in_data   = 4'd0;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        send_beat(4'h1, 1'b0);
        send_beat(4'h2, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_err", 32'(err_cfg), 32'd0);
        check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
        tt_m  = 16'h409B;
        err_m = 1'b0;
        sweep("midrst_tt");
        // Beat counter must restart at zero: a fresh 4-beat load must commit.
        do_load(4, 32'h0000_C3A5);
        sweep("post_rst_load");

        // Randomized mix of loads of varying length and evaluation traffic.
        for (int it = 0; it < 16; it++) begin
            if (($urandom % 2) == 0) begin
                do_load(int'($urandom_range(1, 6)), $urandom);
                sweep("rand_load");
            end else begin
                rand_eval(40);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tt_lut_engine.md
TT_LUT_ENGINE -- requirements
Module: tt_lut_engine

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of truth-table inputs, legal 1..6.
REQ-002 SHALL have parameter LOAD_W, default 4, table bits per config beat, power of two dividing 2**N_IN.
REQ-003 SHALL have parameter RESET_TT, default 16'h409B zero-extended or truncated to 2**N_IN bits, table value after reset.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port cfg_valid  input  1  config beat offered.
REQ-007 SHALL have port cfg_ready  output  1  config beat accepted when cfg_valid&cfg_ready.
REQ-008 SHALL have port cfg_data  input  LOAD_W  table slice, LSB slice first.
REQ-009 SHALL have port cfg_last  input  1  marks final beat of a table load.
REQ-010 SHALL have port in_valid  input  1  input vector offered.
REQ-011 SHALL have port in_ready  output  1  input accepted when in_valid&in_ready.
REQ-012 SHALL have port in_data  input  N_IN  input vector; bit 0 is table index LSB.
REQ-013 SHALL have port out_valid  output  1  result held.
REQ-014 SHALL have port out_ready  input  1  result consumed when out_valid&out_ready.
REQ-015 SHALL have port out_data  output  1  table[in_data] of accepted vector.
REQ-016 SHALL have port err_cfg  output  1  sticky malformed-load flag.

Function
REQ-017 SHALL hold an active table (2**N_IN bits) and a staging table of equal width; BEATS = 2**N_IN/LOAD_W.
REQ-018 SHALL run config FSM states IDLE, LOAD, DRAIN, COMMIT.
REQ-019 IDLE: accepted beat writes staging slice 0, counter=1; cfg_last with BEATS==1 -> COMMIT, cfg_last with BEATS>1 -> err_cfg=1, stay IDLE; otherwise -> LOAD.
REQ-020 LOAD: accepted beat writes staging slice[counter], counter++; cfg_last at counter==BEATS-1 -> COMMIT; cfg_last earlier -> err_cfg=1, IDLE; counter==BEATS-1 without cfg_last -> err_cfg=1, DRAIN.
REQ-021 DRAIN: beats accepted and discarded until one with cfg_last, then IDLE.
REQ-022 COMMIT: one cycle, active<=staging, err_cfg<=0, counter<=0, then IDLE.
REQ-023 cfg_ready SHALL be 1 in IDLE, LOAD, DRAIN and 0 in COMMIT.
REQ-024 Malformed loads SHALL never modify the active table.
REQ-025 Evaluation latency SHALL be 1 cycle: vector accepted at edge k gives out_valid=1, out_data=active[in_data] after edge k.
REQ-026 in_ready SHALL equal (!out_valid | out_ready) gated by REQ-031/REQ-032; back-to-back throughput 1/cycle.
REQ-027 out_valid SHALL drop after a consume with no new accept; out_data SHALL hold stable while out_valid&!out_ready.
REQ-028 Vector accepted in the COMMIT cycle SHALL use the old table; first vector accepted after COMMIT uses the new table.
REQ-029 Simultaneous config beat and input accept SHALL both proceed independently unless REQ-032 stalls input.

Reset
REQ-030 On rst: active=RESET_TT, staging=0, FSM=IDLE, counter=0, out_valid=0, out_data=0, err_cfg=0; reset mid-load abandons the load with active table = RESET_TT.

Configuration
REQ-031 With TT_LUT_SHADOW_EN defined: evaluation continues in LOAD, DRAIN and COMMIT using the active table (double-buffered).
REQ-032 Without TT_LUT_SHADOW_EN: in_ready SHALL be 0 while FSM is LOAD, DRAIN or COMMIT; held results still drain.

Verification
REQ-033 Reset, N_IN=4, stream in_data 0..15, out_ready=1 -> out_data sequence equals bits of 0x409B LSB first, one per cycle.
REQ-034 Load beats 0xF,0x0,0xF,0x0 with cfg_last on 4th -> COMMIT one cycle, next eval in_data=2 gives 1, in_data=5 gives 0, err_cfg=0.
REQ-035 cfg_last on 2nd beat -> err_cfg=1, in_data=0..15 still yields 0x409B; subsequent good load clears err_cfg.
REQ-036 5 beats, cfg_last on 5th -> err_cfg=1 after 4th beat, 5th discarded in DRAIN, table unchanged.
REQ-037 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data stable; shadow build evaluates during LOAD, non-shadow build shows in_ready=0 from first beat until after COMMIT.
REQ-038 rst asserted after 2nd config beat -> FSM IDLE, counter 0, table 0x409B, out_valid=0 next cycle.
